area_log2_seq: RTL
==================

Name: area_log2_seq

Overview:
- Sequential, parametrised log2-area estimator for the blob/object measurement path.
- Accepts an x-span and a y-span in pixels via a valid/ready handshake.
- Finds floor(log2) of each span by iterative shift-and-count, one bit per cycle per axis.
- Returns the log2-area estimate floor(log2 x) + floor(log2 y) on a valid/ready output, plus a held copy of the last result for downstream register reads.

Parameters:
- SPAN_W, 9: significant width of each span input; bits above it are not present.
- OUT_W, 16: width of the area outputs; the result is zero-extended into it.
- CNT_W, clog2(SPAN_W): width of each per-axis MSB counter (4 at default).

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- in_valid  input  1  span pair valid.
- in_ready  output  1  block can accept a span pair.
- xspan_pix  input  SPAN_W  x extent in pixels.
- yspan_pix  input  SPAN_W  y extent in pixels.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- area_log2  output  OUT_W  msbx + msby for the current result.
- zero_span  output  1  either span was 0 for the current result.
- area_q  output  OUT_W  last consumed area_log2, held until the next handshake.
- busy  output  1  state is not IDLE.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; in_ready=1; out_valid=0; area_log2=0; zero_span=0; area_q=0; busy=0; internal shift and count registers cleared.
- Reset asserted mid-SCAN or mid-DONE aborts the operation. No output is produced for the aborted pair.
- FSM states are IDLE, SCAN and DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1, the pair is accepted: load xr<=xspan_pix, yr<=yspan_pix, cx<=0, cy<=0, latch zero flag (xspan_pix==0 || yspan_pix==0); go to SCAN.
- SCAN (in_ready=0):
  - Each cycle, each lane independently: if its register >1, shift it right by 1 and increment its count; otherwise hold.
  - When both registers are <=1 in the same cycle: register area_log2 <= zero-extended (cx+cy), register zero_span, go to DONE.
  - A span of 0 gives msb=0, identical to a span of 1; zero_span distinguishes the two.
- Latency: out_valid rises exactly max(msbx,msby)+1 clock edges after the accepting edge. Examples: 1 edge for spans 1/1; 9 edges for 256/511 at default.
- DONE:
  - out_valid=1; area_log2 and zero_span are stable until the handshake.
  - When out_ready=1: area_q <= area_log2, out_valid drops next cycle, go to IDLE.
  - No new pair is accepted in the same cycle, so at most one result is in flight. Back-to-back throughput is latency+2 cycles per pair.
- Input changes while not in IDLE are ignored; the accepted pair is the captured copy.
- Width: the sum max is 2*(SPAN_W-1) and fits in CNT_W+1 bits. No saturation is needed; OUT_W must be >= CNT_W+1.
- area_log2 holds its last value after out_valid drops (not cleared).

Decomposition:
- Package area_pkg holds:
  - SPAN_W / OUT_W defaults;
  - the state enum (IDLE, SCAN, DONE);
  - a clog2 constant function;
  - the derived CNT_W.
- One sub-module, msb_scan_lane, instantiated twice (x and y):
  - inputs: load, data, enable;
  - outputs: count, done (register <= 1);
  - holds the shift register and counter.
- area_log2_seq contains the FSM, handshake, result and area_q registers.

Test Plan:
- Reset and idle: hold rst=0 mid-SCAN with spans 300/300 -> outputs zero immediately (asynchronous); after release in_ready=1, no out_valid ever appears for the aborted pair.
- Basic: x=8, y=16 -> out_valid 5 edges after accept, area_log2=7, zero_span=0; after out_ready, area_q=7.
- Boundary: x=511, y=511 -> area_log2=16, latency 9; x=1, y=1 -> area_log2=0, latency 1.
- Zero span: x=0, y=64 -> area_log2=6, zero_span=1, latency 7.
- Backpressure: x=100, y=3 with out_ready=0 for 20 cycles -> out_valid, area_log2=7 and zero_span held stable; in_ready=0 and a new in_valid is not accepted; area_q unchanged until out_ready=1.
- Stream: 50 random pairs, random out_ready -> each result equals floor(log2 max(x,1)) + floor(log2 max(y,1)), in order, with no drops or duplicates.

Source files
------------

// File: rtl/area_log2_seq_pkg.sv
// Shared types and sizing for the log2-area estimator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default span/output widths, FSM state enum, clog2 helper, derived counter width.
package area_pkg;

   localparam int SPAN_W_DEF = 9;
   localparam int OUT_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   // Ceiling log2, usable in parameter expressions.
   function automatic int clog2(input int v);
      int r;
      int t;
      r = 0;
      t = v - 1;
      while (t > 0) begin
         r = r + 1;
         t = t >> 1;
      end
      return r;
   endfunction

   localparam int CNT_W_DEF = clog2(SPAN_W_DEF);

endpackage

// File: rtl/area_log2_seq_if.sv
// Span-pair request channel and log2-area result channel, both valid/ready.
// Latency: n/a (wiring only).
// Backpressure: in_ready / out_ready carried across the boundary unchanged.
// Modports: master = producer of spans / consumer of results; slave = the estimator.
interface area_log2_seq_if #(
   parameter int SPAN_W = 9,
   parameter int OUT_W  = 16
);
   logic              in_valid;
   logic              in_ready;
   logic [SPAN_W-1:0] xspan_pix;
   logic [SPAN_W-1:0] yspan_pix;
   logic              out_valid;
   logic              out_ready;
   logic [OUT_W-1:0]  area_log2;
   logic              zero_span;

   modport master (
      output in_valid, xspan_pix, yspan_pix, out_ready,
      input  in_ready, out_valid, area_log2, zero_span
   );

   modport slave (
      input  in_valid, xspan_pix, yspan_pix, out_ready,
      output in_ready, out_valid, area_log2, zero_span
   );
endinterface

// File: rtl/area_log2_seq_msb_scan_lane.sv
// One axis of the MSB search: shifts a captured span right until it is <= 1, counting shifts.
// Latency: floor(log2 data) enabled cycles after load until done.
// Backpressure: none; holds state whenever enable is low or done is reached.
// Ports: clk, rst (async active-low), load/data capture, enable steps, count/done report.
module msb_scan_lane #(
   parameter int SPAN_W = 9,
   parameter int CNT_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [SPAN_W-1:0] data,
   input  logic              enable,
   output logic [CNT_W-1:0]  count,
   output logic              done
);
   logic [SPAN_W-1:0] sr;
   logic [CNT_W-1:0]  cnt;

   // Zero and one both terminate immediately with count 0.
   assign done  = (sr <= SPAN_W'(1));
   assign count = cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr  <= '0;
         cnt <= '0;
      end else if (load) begin
         sr  <= data;
         cnt <= '0;
      end else if (enable && !done) begin
         sr  <= sr >> 1;
         cnt <= cnt + CNT_W'(1);
      end
   end
endmodule

// File: rtl/area_log2_seq.sv
// Log2-area estimator: area_log2 = floor(log2 x) + floor(log2 y), one shift per axis per cycle.
// Latency: out_valid rises max(msbx,msby)+1 edges after the accepting edge.
// Backpressure: one pair in flight; result held in DONE until out_ready, in_ready only in IDLE.
// Ports: clk, rst (async active-low), bus (span/result handshake), area_q (last consumed), busy.
module area_log2_seq
   import area_pkg::*;
#(
   parameter int SPAN_W = SPAN_W_DEF,
   parameter int OUT_W  = OUT_W_DEF,
   parameter int CNT_W  = clog2(SPAN_W)
) (
   input  logic                clk,
   input  logic                rst,
   area_log2_seq_if.slave      bus,
   output logic [OUT_W-1:0]    area_q,
   output logic                busy
);
   state_t           state;
   state_t           state_nxt;
   logic             accept;
   logic             scan_en;
   logic             finish;
   logic             handshake;
   logic [CNT_W-1:0] cnt_x;
   logic [CNT_W-1:0] cnt_y;
   logic             done_x;
   logic             done_y;
   logic [CNT_W:0]   sum_c;
   logic             zero_lat;
   logic [OUT_W-1:0] area_r;
   logic             zero_r;

   assign accept    = (state == IDLE) && bus.in_valid;
   assign scan_en   = (state == SCAN);
   assign finish    = scan_en && done_x && done_y;
   assign handshake = (state == DONE) && bus.out_ready;
   // One extra bit so the worst case 2*(SPAN_W-1) never wraps.
   assign sum_c     = {1'b0, cnt_x} + {1'b0, cnt_y};

   msb_scan_lane #(.SPAN_W(SPAN_W), .CNT_W(CNT_W)) u_lane_x (
      .clk    (clk),
      .rst    (rst),
      .load   (accept),
      .data   (bus.xspan_pix),
      .enable (scan_en),
      .count  (cnt_x),
      .done   (done_x)
   );

   msb_scan_lane #(.SPAN_W(SPAN_W), .CNT_W(CNT_W)) u_lane_y (
      .clk    (clk),
      .rst    (rst),
      .load   (accept),
      .data   (bus.yspan_pix),
      .enable (scan_en),
      .count  (cnt_y),
      .done   (done_y)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.in_valid)     state_nxt = SCAN;
         SCAN:    if (done_x && done_y) state_nxt = DONE;
         DONE:    if (bus.out_ready)    state_nxt = IDLE;
         default:                       state_nxt = IDLE;
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.out_valid = 1'b0;
      busy          = 1'b1;
      case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            busy         = 1'b0;
         end
         DONE:    bus.out_valid = 1'b1;
         default: ;
      endcase
   end

   // Result path: zero flag captured with the pair, result captured when both lanes finish,
   // and the consumed copy captured on the output handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         zero_lat <= 1'b0;
         area_r   <= '0;
         zero_r   <= 1'b0;
         area_q   <= '0;
      end else begin
         if (accept)
            zero_lat <= (bus.xspan_pix == '0) || (bus.yspan_pix == '0);
         if (finish) begin
            area_r <= OUT_W'(sum_c);
            zero_r <= zero_lat;
         end
         if (handshake)
            area_q <= area_r;
      end
   end

   assign bus.area_log2 = area_r;
   assign bus.zero_span = zero_r;
endmodule
